// File: rtl/instr_fetch.sv
// instr_fetch: fetch unit with one outstanding request, decode field split and PC sequencing.
// Ports: clk, rst_n (synchronous, active-low);
//        ImemReq/ImemAddr out, ImemReady/ImemData in: instruction memory handshake;
//        Stall/Branch/Zero/Jump/RsData in: decode hold and control-flow feedback;
//        InstrValid, Opcode, Funct, Rs, Rt, Rd, Imm16, Imm26, PC, PCPlus4, InstrCount out.
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        ImemReq,
   output logic [31:0] ImemAddr,
   input  logic        ImemReady,
   input  logic [31:0] ImemData,
   input  logic        Stall,
   input  logic        Branch,
   input  logic        Zero,
   input  logic [1:0]  Jump,
   input  logic [31:0] RsData,
   output logic        InstrValid,
   output logic [5:0]  Opcode,
   output logic [5:0]  Funct,
   output logic [4:0]  Rs,
   output logic [4:0]  Rt,
   output logic [4:0]  Rd,
   output logic [15:0] Imm16,
   output logic [25:0] Imm26,
   output logic [31:0] PC,
   output logic [31:0] PCPlus4,
   output logic [31:0] InstrCount
);
   typedef enum logic {FETCH, HOLD} state_t;
   state_t      state;
   logic        req;
   logic        valid;
   logic [31:0] instr;
   logic [31:0] pc;
   logic [31:0] count;
   logic [31:0] pc_plus4;
   logic [31:0] br_target;
   logic [31:0] next_pc;
   assign pc_plus4  = pc + 32'd4;
   assign br_target = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};
   assign next_pc   = Jump == 2'b10 ? {RsData[31:2], 2'b00} :
                      Jump == 2'b01 ? {pc_plus4[31:28], instr[25:0], 2'b00} :
                      (Branch && Zero) ? br_target : pc_plus4;
   // req is registered separately from state so that it stays low through reset
   // and the first request appears only once rst_n has been sampled high.
   // The captured word is cleared on consumption so idle fields read as zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= FETCH;
         req   <= 1'b0;
         valid <= 1'b0;
         instr <= '0;
         pc    <= {RESET_PC[31:2], 2'b00};
         count <= '0;
      end else if (state == FETCH) begin
         if (req && ImemReady) begin
            instr <= ImemData;
            valid <= 1'b1;
            req   <= 1'b0;
            state <= HOLD;
         end else begin
            req <= 1'b1;
         end
      end else if (!Stall) begin
         pc    <= next_pc;
         valid <= 1'b0;
         instr <= '0;
         req   <= 1'b1;
         count <= count + 32'd1;
         state <= FETCH;
      end
   end
   assign ImemReq    = req;
   assign ImemAddr   = pc;
   assign InstrValid = valid;
   assign Opcode     = instr[31:26];
   assign Funct      = instr[5:0];
   assign Rs         = instr[25:21];
   assign Rt         = instr[20:16];
   assign Rd         = instr[15:11];
   assign Imm16      = instr[15:0];
   assign Imm26      = instr[25:0];
   assign PC         = pc;
   assign PCPlus4    = pc_plus4;
   assign InstrCount = count;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: scoreboard bench for instr_fetch with directed fetch/consume vectors.
// Ports: none (top-level bench).
module tb_instr_fetch;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ImemReq;
   logic [31:0] ImemAddr;
   logic        ImemReady = 1'b0;
   logic [31:0] ImemData = '0;
   logic        Stall = 1'b1;
   logic        Branch = 1'b0;
   logic        Zero = 1'b0;
   logic [1:0]  Jump = 2'b00;
   logic [31:0] RsData = '0;
   logic        InstrValid;
   logic [5:0]  Opcode;
   logic [5:0]  Funct;
   logic [4:0]  Rs;
   logic [4:0]  Rt;
   logic [4:0]  Rd;
   logic [15:0] Imm16;
   logic [25:0] Imm26;
   logic [31:0] PC;
   logic [31:0] PCPlus4;
   logic [31:0] InstrCount;
   int          tests = 0;
   int          fails = 0;
   logic [31:0] exp_cnt = '0;
   logic [31:0] exp_addr[$];
   logic [31:0] exp_pc[$];
   logic [31:0] exp_word[$];
   always #5 clk = ~clk;
   instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst_n(rst_n), .ImemReq(ImemReq), .ImemAddr(ImemAddr),
      .ImemReady(ImemReady), .ImemData(ImemData), .Stall(Stall), .Branch(Branch),
      .Zero(Zero), .Jump(Jump), .RsData(RsData), .InstrValid(InstrValid),
      .Opcode(Opcode), .Funct(Funct), .Rs(Rs), .Rt(Rt), .Rd(Rd), .Imm16(Imm16),
      .Imm26(Imm26), .PC(PC), .PCPlus4(PCPlus4), .InstrCount(InstrCount)
   );
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      tests++;
      if (act !== want) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, want);
      end
   endtask
   task automatic miss(input string name);
      tests++;
      fails++;
      $display("FAIL %s: got nothing, expected an event", name);
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   // Monitor: pops the scoreboard whenever a new request or a new instruction appears.
   logic        req_q = 1'b0;
   logic        val_q = 1'b0;
   logic [31:0] addr_q = '0;
   always @(negedge clk) begin
      if (ImemReq && !req_q) begin
         if (exp_addr.size() == 0) miss("req_unexpected");
         else chk("req_addr", ImemAddr, exp_addr.pop_front());
      end
      if (ImemReq && req_q) chk("addr_stable", ImemAddr, addr_q);
      if (InstrValid && !val_q) begin
         if (exp_word.size() == 0 || exp_pc.size() == 0) miss("valid_unexpected");
         else begin
            logic [31:0] w;
            logic [31:0] p;
            w = exp_word.pop_front();
            p = exp_pc.pop_front();
            chk("opcode", {26'b0, Opcode}, {26'b0, w[31:26]});
            chk("rs", {27'b0, Rs}, {27'b0, w[25:21]});
            chk("rt", {27'b0, Rt}, {27'b0, w[20:16]});
            chk("rd", {27'b0, Rd}, {27'b0, w[15:11]});
            chk("funct", {26'b0, Funct}, {26'b0, w[5:0]});
            chk("imm16", {16'b0, Imm16}, {16'b0, w[15:0]});
            chk("imm26", {6'b0, Imm26}, {6'b0, w[25:0]});
            chk("pc", PC, p);
            chk("pcplus4", PCPlus4, p + 32'd4);
         end
      end
      if (!InstrValid) begin
         chk("idle_fields_a", {Opcode, Imm26}, 32'h0);
         chk("idle_fields_b", {5'b0, Rs, Rt, Rd, Funct, Funct}, 32'h0);
      end
      req_q  <= ImemReq;
      val_q  <= InstrValid;
      addr_q <= ImemAddr;
   end
   task automatic fetch(input logic [31:0] word, input logic [31:0] pc, input int waits);
      int n = 0;
      while (!ImemReq && n < 40) begin
         tick();
         n++;
      end
      if (!ImemReq) begin
         miss("fetch_timeout");
         return;
      end
      chk("fetch_addr", ImemAddr, pc);
      exp_pc.push_back(pc);
      exp_word.push_back(word);
      repeat (waits) tick();
      ImemReady = 1'b1;
      ImemData  = word;
      tick();
      ImemReady = 1'b0;
      ImemData  = 32'hDEAD_BEEF;
      chk("valid_after_ready", {31'b0, InstrValid}, 32'd1);
   endtask
   task automatic consume(input logic br, input logic zr, input logic [1:0] jp,
                          input logic [31:0] rs, input logic [31:0] nxt);
      int n = 0;
      while (!InstrValid && n < 40) begin
         tick();
         n++;
      end
      if (!InstrValid) begin
         miss("consume_timeout");
         return;
      end
      exp_addr.push_back(nxt);
      Branch = br;
      Zero   = zr;
      Jump   = jp;
      RsData = rs;
      Stall  = 1'b0;
      tick();
      Stall  = 1'b1;
      Branch = 1'b0;
      Zero   = 1'b0;
      Jump   = 2'b00;
      RsData = 32'h5555_5555;
      exp_cnt = exp_cnt + 32'd1;
      chk("consumed_valid", {31'b0, InstrValid}, 32'd0);
      chk("consumed_req", {31'b0, ImemReq}, 32'd1);
      chk("next_pc", PC, nxt);
      chk("count", InstrCount, exp_cnt);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1);
   end
   initial begin
      repeat (3) tick();
      chk("rst_req", {31'b0, ImemReq}, 32'd0);
      chk("rst_valid", {31'b0, InstrValid}, 32'd0);
      chk("rst_pc", PC, 32'h0);
      chk("rst_count", InstrCount, 32'h0);
      exp_addr.push_back(32'h0);
      rst_n = 1'b1;
      tick();
      chk("req_after_reset", {31'b0, ImemReq}, 32'd1);
      fetch(32'h2008_0005, 32'h0, 2);
      chk("addi_opcode", {26'b0, Opcode}, 32'h08);
      chk("addi_rt", {27'b0, Rt}, 32'd8);
      chk("addi_imm", {16'b0, Imm16}, 32'd5);
      chk("addi_pc", PC, 32'h0);
      for (int i = 0; i < 5; i++) begin
         ImemReady = (i == 2);
         ImemData  = 32'hFFFF_FFFF;
         tick();
         chk("stall_opcode", {26'b0, Opcode}, 32'h08);
         chk("stall_imm", {16'b0, Imm16}, 32'd5);
         chk("stall_pc", PC, 32'h0);
         chk("stall_count", InstrCount, 32'h0);
         chk("stall_req", {31'b0, ImemReq}, 32'd0);
         chk("stall_valid", {31'b0, InstrValid}, 32'd1);
      end
      ImemReady = 1'b0;
      consume(1'b0, 1'b0, 2'b00, 32'h0, 32'h4);
      fetch(32'h0000_0008, 32'h4, 0);
      consume(1'b0, 1'b0, 2'b10, 32'h13, 32'h10);
      fetch(32'h1000_FFFE, 32'h10, 1);
      consume(1'b1, 1'b1, 2'b00, 32'h0, 32'h0C);
      fetch(32'h1000_FFFE, 32'h0C, 0);
      consume(1'b0, 1'b0, 2'b10, 32'h10, 32'h10);
      fetch(32'h1000_FFFE, 32'h10, 3);
      consume(1'b1, 1'b0, 2'b00, 32'h0, 32'h14);
      fetch(32'h1000_FFFE, 32'h14, 0);
      consume(1'b1, 1'b1, 2'b10, 32'h203, 32'h200);
      fetch(32'h0800_0040, 32'h200, 0);
      consume(1'b0, 1'b0, 2'b10, 32'h1000_0000, 32'h1000_0000);
      fetch(32'h0800_0040, 32'h1000_0000, 1);
      consume(1'b1, 1'b1, 2'b01, 32'h0, 32'h1000_0100);
      fetch(32'h0800_0040, 32'h1000_0100, 0);
      consume(1'b0, 1'b0, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFC);
      fetch(32'h0000_0020, 32'hFFFF_FFFC, 0);
      chk("wrap_pcplus4", PCPlus4, 32'h0);
      consume(1'b0, 1'b0, 2'b11, 32'h1234, 32'h0);
      fetch(32'h0000_0020, 32'h0, 0);
      force dut.count = 32'hFFFF_FFFF;
      tick();
      release dut.count;
      tick();
      chk("count_forced", InstrCount, 32'hFFFF_FFFF);
      exp_cnt = 32'hFFFF_FFFF;
      consume(1'b0, 1'b0, 2'b00, 32'h0, 32'h4);
      tick();
      chk("midfetch_req", {31'b0, ImemReq}, 32'd1);
      rst_n     = 1'b0;
      ImemReady = 1'b1;
      ImemData  = 32'hFC00_0000;
      tick();
      chk("rst_mid_req", {31'b0, ImemReq}, 32'd0);
      chk("rst_mid_valid", {31'b0, InstrValid}, 32'd0);
      tick();
      chk("rst_mid_req2", {31'b0, ImemReq}, 32'd0);
      chk("rst_mid_valid2", {31'b0, InstrValid}, 32'd0);
      chk("rst_mid_count", InstrCount, 32'h0);
      ImemReady = 1'b0;
      exp_cnt = '0;
      exp_addr.push_back(32'h0);
      rst_n = 1'b1;
      tick();
      chk("req_after_reset2", {31'b0, ImemReq}, 32'd1);
      chk("addr_after_reset2", ImemAddr, 32'h0);
      fetch(32'h2008_0005, 32'h0, 0);
      consume(1'b0, 1'b0, 2'b00, 32'h0, 32'h4);
      repeat (3) tick();
      chk("sb_addr_empty", exp_addr.size(), 32'd0);
      chk("sb_word_empty", exp_word.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
